// File: rtl/gpu_pkg.sv
// Shared types and constants for the voxel_gpu memory arbiter.
package gpu;

    typedef logic [31:0] mem_addr_t;
    typedef logic [7:0]  mem_byte_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RDWAIT
    } arb_state_t;

    localparam int unsigned ARB_MAX_REQ = 8;

endpackage

// File: rtl/gpu_mem_arbiter_rr_picker.sv
// Combinational circular priority encoder: first requester strictly after rr_ptr wins.
module gpu_rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned j;
        valid = 1'b0;
        index = '0;
        j     = 0;
        // Scan rr_ptr+1 .. rr_ptr+NUM_REQ so the last owner has lowest priority.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            j = (32'(rr_ptr) + i) % NUM_REQ;
            if (!valid && req[j[IdxW-1:0]]) begin
                valid = 1'b1;
                index = j[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide m1 Avalon master between NUM_REQ requesters.
// Optional watchdog enabled by defining GPU_ARB_TIMEOUT_EN.
module gpu_mem_arbiter
    import gpu::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0][31:0] req_address,
    input  logic [NUM_REQ-1:0]       req_read,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][7:0]  req_writedata,
    output logic [NUM_REQ-1:0]       req_waitrequest,
    output logic [7:0]               req_readdata,
    output logic [NUM_REQ-1:0]       req_readdatavalid,
    output logic [31:0]              m1_address,
    output logic                     m1_read,
    output logic                     m1_write,
    output logic [7:0]               m1_writedata,
    input  logic                     m1_waitrequest,
    input  logic [7:0]               m1_readdata,
    input  logic                     m1_readdatavalid,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            own_rd, own_wr;
    logic            expire;
    logic            timeout_hit;

    gpu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req_read | req_write),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    // Read wins when a requester raises both commands.
    assign own_rd = req_read[owner_q];
    assign own_wr = req_write[owner_q] & ~own_rd;
    assign busy   = (state_q != ARB_IDLE);

`ifdef GPU_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // >= so a GRANT->RDWAIT hop on the limit cycle still expires one cycle later.
    assign expire      = busy && (cnt_q >= 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_q;

    always_comb begin
        cnt_d         = (state_q == ARB_IDLE) ? 16'd0 : cnt_q + 16'd1;
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    logic unused_cfg;

    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{timeout_hit, 32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        rr_ptr_d          = rr_ptr_q;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        req_readdata      = '0;
        m1_address        = '0;
        m1_read           = 1'b0;
        m1_write          = 1'b0;
        m1_writedata      = '0;
        timeout_hit       = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                m1_address   = req_address[owner_q];
                m1_read      = own_rd;
                m1_write     = own_wr;
                m1_writedata = req_writedata[owner_q];
                if (!m1_waitrequest) begin
                    req_waitrequest[owner_q] = 1'b0;
                    if (own_rd && !m1_readdatavalid) begin
                        state_d = ARB_RDWAIT;
                    end else begin
                        req_readdatavalid[owner_q] = own_rd;
                        req_readdata               = own_rd ? m1_readdata : 8'h00;
                        rr_ptr_d                   = owner_q;
                        state_d                    = ARB_IDLE;
                    end
                end else if (expire) begin
                    timeout_hit                = 1'b1;
                    req_waitrequest[owner_q]   = 1'b0;
                    req_readdatavalid[owner_q] = own_rd;
                    rr_ptr_d                   = owner_q;
                    state_d                    = ARB_IDLE;
                end
            end
            ARB_RDWAIT: begin
                if (m1_readdatavalid) begin
                    req_readdatavalid[owner_q] = 1'b1;
                    req_readdata               = m1_readdata;
                    rr_ptr_d                   = owner_q;
                    state_d                    = ARB_IDLE;
                end else if (expire) begin
                    timeout_hit                = 1'b1;
                    req_waitrequest[owner_q]   = 1'b0;
                    req_readdatavalid[owner_q] = 1'b1;
                    rr_ptr_d                   = owner_q;
                    state_d                    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IdxW'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: OCRAM/SDRAM slave model plus per-scenario tasks.
module tb_gpu_mem_arbiter;

    localparam int NR = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [NR-1:0][31:0] req_address;
    logic [NR-1:0]       req_read;
    logic [NR-1:0]       req_write;
    logic [NR-1:0][7:0]  req_writedata;
    logic [NR-1:0]       req_waitrequest;
    logic [7:0]          req_readdata;
    logic [NR-1:0]       req_readdatavalid;
    logic [31:0]         m1_address;
    logic                m1_read;
    logic                m1_write;
    logic [7:0]          m1_writedata;
    logic                m1_waitrequest;
    logic [7:0]          m1_readdata;
    logic                m1_readdatavalid;
    logic                busy;
    logic                timeout_err;

    // Slave model: OCRAM answers in the accept cycle, otherwise tasks drive sl_*.
    logic       slv_ocram;
    logic       sl_wait;
    logic       sl_rdv;
    logic [7:0] sl_rdata;
    logic [15:0] mem16 [4];

    int n_vec = 0;
    int n_err = 0;

    gpu_mem_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_address       (req_address),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .m1_address        (m1_address),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_writedata      (m1_writedata),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always_comb begin
        if (slv_ocram) begin
            m1_waitrequest   = 1'b0;
            m1_readdatavalid = m1_read;
            m1_readdata      = m1_read ? (m1_address[7:0] ^ 8'h5E) : 8'h00;
        end else begin
            m1_waitrequest   = sl_wait;
            m1_readdatavalid = sl_rdv;
            m1_readdata      = sl_rdata;
        end
    end

    // 16-bit SDRAM word store, byte lane chosen by address bit 0.
    always @(posedge clock) begin
        if (m1_write && !m1_waitrequest) begin
            if (m1_address[0]) mem16[m1_address[2:1]][15:8] <= m1_writedata;
            else               mem16[m1_address[2:1]][7:0]  <= m1_writedata;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_read = 4'hF;
        step();
        step();
        @(negedge clock);
        n_vec++; if (req_waitrequest !== 4'hF) begin n_err++;
            $display("FAIL reset_waitreq: got %h want f", req_waitrequest); end
        n_vec++; if (req_readdatavalid !== 4'h0) begin n_err++;
            $display("FAIL reset_rdv: got %h want 0", req_readdatavalid); end
        n_vec++; if ({m1_read, m1_write, busy, timeout_err} !== 4'b0000) begin n_err++;
            $display("FAIL reset_flags: got %b want 0000", {m1_read, m1_write, busy, timeout_err}); end
        n_vec++; if (m1_address !== 32'h0 || m1_writedata !== 8'h00) begin n_err++;
            $display("FAIL reset_m1_bus: got %h/%h want 0/0", m1_address, m1_writedata); end
        n_vec++; if (req_readdata !== 8'h00) begin n_err++;
            $display("FAIL reset_readdata: got %h want 00", req_readdata); end
        step();
        reset = 1'b1;
        req_read = '0;
    endtask

    task automatic test_ocram_read();
        step();
        slv_ocram = 1'b1;
        req_address[0] = 32'h0800_0004;
        req_read[0] = 1'b1;
        @(negedge clock);
        n_vec++; if (m1_read !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL ocram_c1: got read=%b busy=%b want 0 0", m1_read, busy); end
        step();
        @(negedge clock);
        n_vec++; if (m1_read !== 1'b1 || m1_address !== 32'h0800_0004) begin n_err++;
            $display("FAIL ocram_c2_cmd: got read=%b addr=%h want 1 08000004", m1_read, m1_address); end
        n_vec++; if (req_waitrequest !== 4'b1110 || req_readdatavalid !== 4'b0001) begin n_err++;
            $display("FAIL ocram_c2_hs: got wr=%b rdv=%b want 1110 0001",
                     req_waitrequest, req_readdatavalid); end
        n_vec++; if (req_readdata !== 8'h5A) begin n_err++;
            $display("FAIL ocram_c2_data: got %h want 5a", req_readdata); end
        step();
        req_read[0] = 1'b0;
        @(negedge clock);
        n_vec++; if (busy !== 1'b0 || req_readdatavalid !== 4'h0) begin n_err++;
            $display("FAIL ocram_c3: got busy=%b rdv=%b want 0 0000", busy, req_readdatavalid); end
    endtask

    task automatic test_sdram_write();
        step();
        slv_ocram = 1'b0;
        sl_wait = 1'b1;
        req_address[1] = 32'hC000_0001;
        req_writedata[1] = 8'h3C;
        req_write[1] = 1'b1;
        @(negedge clock);
        n_vec++; if (m1_write !== 1'b0) begin n_err++;
            $display("FAIL sdw_c1: got write=%b want 0", m1_write); end
        step();
        @(negedge clock);
        n_vec++; if (m1_write !== 1'b1 || m1_address !== 32'hC000_0001 || m1_writedata !== 8'h3C)
            begin n_err++;
            $display("FAIL sdw_c2_cmd: got %b %h %h want 1 c0000001 3c",
                     m1_write, m1_address, m1_writedata); end
        n_vec++; if (req_waitrequest !== 4'hF) begin n_err++;
            $display("FAIL sdw_c2_wait: got %b want 1111", req_waitrequest); end
        step();
        sl_wait = 1'b0;
        @(negedge clock);
        n_vec++; if (m1_write !== 1'b1 || req_waitrequest !== 4'b1101) begin n_err++;
            $display("FAIL sdw_c3: got write=%b wr=%b want 1 1101", m1_write, req_waitrequest); end
        step();
        req_write[1] = 1'b0;
        sl_wait = 1'b1;
        @(negedge clock);
        n_vec++; if (m1_write !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL sdw_c4: got write=%b busy=%b want 0 0", m1_write, busy); end
        n_vec++; if (mem16[0][15:8] !== 8'h3C) begin n_err++;
            $display("FAIL sdw_mem: got %h want 3c", mem16[0][15:8]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdv;
        logic [7:0] exp_data;
        int         k;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        slv_ocram = 1'b1;
        for (int i = 0; i < NR; i++) req_address[i] = 32'h10 + 32'(i);
        req_read = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c % 2 == 0) begin
                k        = (c / 2 - 1) % 4;
                exp_rdv  = 4'b0001 << k;
                exp_data = 8'(8'h10 + k) ^ 8'h5E;
            end else begin
                exp_rdv  = 4'b0000;
                exp_data = 8'h00;
            end
            n_vec++; if (req_readdatavalid !== exp_rdv || req_waitrequest !== ~exp_rdv) begin
                n_err++;
                $display("FAIL rr_c%0d_grant: got rdv=%b wr=%b want %b %b", c,
                         req_readdatavalid, req_waitrequest, exp_rdv, ~exp_rdv); end
            n_vec++; if (req_readdata !== exp_data) begin n_err++;
                $display("FAIL rr_c%0d_data: got %h want %h", c, req_readdata, exp_data); end
            step();
        end
        req_read = '0;
    endtask

    task automatic test_split_read();
        step();
        slv_ocram = 1'b0;
        sl_wait = 1'b0;
        sl_rdv = 1'b0;
        req_address[2] = 32'h4000_0020;
        req_read[2] = 1'b1;
        req_address[3] = 32'hC000_0006;
        req_writedata[3] = 8'h77;
        req_write[3] = 1'b1;
        @(negedge clock);
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL split_idle: got busy=%b want 0", busy); end
        step();
        @(negedge clock);
        n_vec++; if (m1_read !== 1'b1 || m1_address !== 32'h4000_0020 ||
                     req_waitrequest !== 4'b1011 || req_readdatavalid !== 4'h0) begin n_err++;
            $display("FAIL split_accept: got rd=%b a=%h wr=%b rdv=%b want 1 40000020 1011 0000",
                     m1_read, m1_address, req_waitrequest, req_readdatavalid); end
        for (int i = 1; i <= 3; i++) begin
            step();
            req_read[2] = 1'b0;
            if (i == 3) begin
                sl_rdv = 1'b1;
                sl_rdata = 8'hA5;
            end
            @(negedge clock);
            n_vec++; if (m1_read !== 1'b0 || m1_write !== 1'b0 || busy !== 1'b1) begin n_err++;
                $display("FAIL split_n%0d_bus: got rd=%b wr=%b busy=%b want 0 0 1",
                         i, m1_read, m1_write, busy); end
            n_vec++; if (req_readdatavalid !== ((i == 3) ? 4'b0100 : 4'b0000) ||
                         req_readdata !== ((i == 3) ? 8'hA5 : 8'h00)) begin n_err++;
                $display("FAIL split_n%0d_rdv: got rdv=%b data=%h", i,
                         req_readdatavalid, req_readdata); end
        end
        step();
        sl_rdv = 1'b0;
        @(negedge clock);
        n_vec++; if (busy !== 1'b0 || req_readdatavalid !== 4'h0) begin n_err++;
            $display("FAIL split_done: got busy=%b rdv=%b want 0 0000", busy, req_readdatavalid); end
        step();
        @(negedge clock);
        n_vec++; if (m1_write !== 1'b1 || m1_address !== 32'hC000_0006 ||
                     req_waitrequest !== 4'b0111) begin n_err++;
            $display("FAIL split_next_grant: got wr=%b a=%h wreq=%b want 1 c0000006 0111",
                     m1_write, m1_address, req_waitrequest); end
        step();
        req_write[3] = 1'b0;
        @(negedge clock);
        n_vec++; if (mem16[3][7:0] !== 8'h77 || busy !== 1'b0) begin n_err++;
            $display("FAIL split_mem: got %h busy=%b want 77 0", mem16[3][7:0], busy); end
    endtask

    task automatic test_reset_midop();
        step();
        slv_ocram = 1'b0;
        sl_wait = 1'b1;
        req_address[1] = 32'hC000_0002;
        req_read[1] = 1'b1;
        step();
        @(negedge clock);
        n_vec++; if (m1_read !== 1'b1 || m1_address !== 32'hC000_0002) begin n_err++;
            $display("FAIL midop_grant: got rd=%b a=%h want 1 c0000002", m1_read, m1_address); end
        step();
        reset = 1'b0;
        step();
        sl_wait = 1'b0;
        sl_rdv = 1'b1;
        sl_rdata = 8'hEE;
        @(negedge clock);
        n_vec++; if (req_waitrequest !== 4'hF || req_readdatavalid !== 4'h0 ||
                     req_readdata !== 8'h00) begin n_err++;
            $display("FAIL midop_req_side: got wr=%b rdv=%b d=%h want 1111 0000 00",
                     req_waitrequest, req_readdatavalid, req_readdata); end
        n_vec++; if (m1_read !== 1'b0 || m1_address !== 32'h0 || busy !== 1'b0) begin n_err++;
            $display("FAIL midop_m1_side: got rd=%b a=%h busy=%b want 0 0 0",
                     m1_read, m1_address, busy); end
        step();
        reset = 1'b1;
        sl_rdv = 1'b0;
        slv_ocram = 1'b1;
        req_read = 4'b0101;
        req_address[0] = 32'h20;
        req_address[2] = 32'h22;
        step();
        @(negedge clock);
        n_vec++; if (req_readdatavalid !== 4'b0001 || req_readdata !== 8'h7E) begin n_err++;
            $display("FAIL midop_ptr0: got rdv=%b d=%h want 0001 7e",
                     req_readdatavalid, req_readdata); end
        step();
        req_read[0] = 1'b0;
        step();
        @(negedge clock);
        n_vec++; if (req_readdatavalid !== 4'b0100 || req_readdata !== 8'h7C) begin n_err++;
            $display("FAIL midop_ptr2: got rdv=%b d=%h want 0100 7c",
                     req_readdatavalid, req_readdata); end
        step();
        req_read[2] = 1'b0;
    endtask

`ifdef GPU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        slv_ocram = 1'b0;
        sl_wait = 1'b1;
        sl_rdv = 1'b0;
        req_address[0] = 32'h0;
        req_read[0] = 1'b1;
        for (int c = 2; c <= 17; c++) begin
            step();
            @(negedge clock);
            n_vec++; if (req_readdatavalid !== ((c == 17) ? 4'b0001 : 4'b0000) ||
                         req_waitrequest !== ((c == 17) ? 4'b1110 : 4'b1111) ||
                         req_readdata !== 8'h00 || timeout_err !== 1'b0) begin n_err++;
                $display("FAIL timeout_c%0d: got rdv=%b wr=%b d=%h err=%b", c,
                         req_readdatavalid, req_waitrequest, req_readdata, timeout_err); end
        end
        step();
        req_read[0] = 1'b0;
        @(negedge clock);
        n_vec++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL timeout_set: got err=%b busy=%b want 1 0", timeout_err, busy); end
        repeat (4) step();
        @(negedge clock);
        n_vec++; if (timeout_err !== 1'b1) begin n_err++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (timeout_err !== 1'b0) begin n_err++;
            $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        step();
        slv_ocram = 1'b0;
        sl_wait = 1'b1;
        sl_rdv = 1'b0;
        req_address[0] = 32'h0;
        req_read[0] = 1'b1;
        bad = 0;
        repeat (40) begin
            step();
            @(negedge clock);
            if (req_readdatavalid !== 4'h0 || timeout_err !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++;
            $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad); end
        n_vec++; if (busy !== 1'b1 || m1_read !== 1'b1) begin n_err++;
            $display("FAIL no_timeout_busy: got busy=%b rd=%b want 1 1", busy, m1_read); end
        step();
        reset = 1'b0;
        req_read[0] = 1'b0;
        step();
        reset = 1'b1;
    endtask
`endif

    initial begin
        req_address   = '0;
        req_read      = '0;
        req_write     = '0;
        req_writedata = '0;
        slv_ocram     = 1'b1;
        sl_wait       = 1'b0;
        sl_rdv        = 1'b0;
        sl_rdata      = 8'h00;
        test_reset();
        test_ocram_read();
        test_sdram_write();
        test_round_robin();
        test_split_read();
        test_reset_midop();
`ifdef GPU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
